// File: rtl/button_debounce_pulse.sv
// Turns a raw, bouncy, active-low push-button into a clean debounced level
// plus one-clock press/release pulses, with optional hold-to-auto-repeat.
module button_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 0,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RP_LAST   = CNT_W'(REPEAT_CYCLES - 1);
  localparam bit               REPEAT_EN = (REPEAT_CYCLES != 0);

  state_t           state;
  logic             s1;
  logic             s2;
  logic             btn_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rcnt;

  // Two-flop synchroniser; idles at 1 so reset looks like "not pressed".
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
    end
  end

  assign btn_s = s2;

  // cnt is cleared on every state entry; rcnt survives release bounces so a
  // glitchy hold does not restart the repeat period.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RELEASED;
      cnt           <= '0;
      rcnt          <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        RELEASED: begin
          if (!btn_s) begin
            state <= PRESS_CHK;
            cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (btn_s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state       <= PRESSED;
            cnt         <= '0;
            press_pulse <= 1'b1;
            btn_level   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (btn_s) begin
            state <= RELEASE_CHK;
            cnt   <= '0;
          end else if (REPEAT_EN) begin
            if (rcnt == RP_LAST) begin
              rcnt        <= '0;
              press_pulse <= 1'b1;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
        end
        RELEASE_CHK: begin
          if (!btn_s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state         <= RELEASED;
            cnt           <= '0;
            rcnt          <= '0;
            release_pulse <= 1'b1;
            btn_level     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
